// File: rtl/fun_req_master_pkg.sv
// Shared defaults and FSM encoding for the fun request master.
// Imported by the interface, the wait timer and the top.
package fun_req_master_pkg;

  localparam int A_W_DEF   = 8;
  localparam int B_W_DEF   = 8;
  localparam int R_W_DEF   = 11;
  localparam int CNT_W_DEF = 11;
  localparam int MAX_WAIT_DEF   = 2000;
  localparam int RST_CYCLES_DEF = 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_SETTLE  = 3'd2,
    S_WAIT    = 3'd3,
    S_RECOVER = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  function automatic int rc_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fun_req_master_if.sv
// Request, fun-side and response signals of the fun request master.
// master = the initiator, slave = request source/fun/consumer side.
interface fun_req_master_if
  import fun_req_master_pkg::*;
#(
  parameter int A_W   = A_W_DEF,
  parameter int B_W   = B_W_DEF,
  parameter int R_W   = R_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic             req_valid;
  logic             req_ready;
  logic [A_W-1:0]   req_a;
  logic [B_W-1:0]   req_b;

  logic [A_W-1:0]   fun_a;
  logic [B_W-1:0]   fun_b;
  logic             fun_start;
  logic             fun_rst;
  logic             fun_busy;
  logic [R_W-1:0]   fun_result;

  logic             res_valid;
  logic             res_ready;
  logic [R_W-1:0]   res_data;
  logic [CNT_W-1:0] res_cycles;
  logic             res_timeout;

  modport master (
    input  req_valid, req_a, req_b,
    output req_ready,
    output fun_a, fun_b, fun_start, fun_rst,
    input  fun_busy, fun_result,
    output res_valid, res_data, res_cycles, res_timeout,
    input  res_ready
  );

  modport slave (
    output req_valid, req_a, req_b,
    input  req_ready,
    input  fun_a, fun_b, fun_start, fun_rst,
    output fun_busy, fun_result,
    input  res_valid, res_data, res_cycles, res_timeout,
    output res_ready
  );

endinterface

// File: rtl/fun_req_master_wait_timer.sv
// Busy-poll counter: clear, enable, terminal count at MAX_WAIT_CYCLES.
// Saturates at the terminal count so it can never wrap.
module fun_req_master_wait_timer
  import fun_req_master_pkg::*;
#(
  parameter int CNT_W           = CNT_W_DEF,
  parameter int MAX_WAIT_CYCLES = MAX_WAIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  assign tc = (cnt == CNT_W'(MAX_WAIT_CYCLES));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fun_req_master.sv
// Initiator for the fun start/busy protocol: one op in flight,
// bounded busy polling, timeout recovery via fun_rst.
module fun_req_master
  import fun_req_master_pkg::*;
#(
  parameter int A_W             = A_W_DEF,
  parameter int B_W             = B_W_DEF,
  parameter int R_W             = R_W_DEF,
  parameter int CNT_W           = CNT_W_DEF,
  parameter int MAX_WAIT_CYCLES = MAX_WAIT_DEF,
  parameter int RST_CYCLES      = RST_CYCLES_DEF
) (
  input logic               clk,
  input logic               rst,
  fun_req_master_if.master  bus
);

  localparam int RC_W = rc_width(RST_CYCLES);

  state_t           state;
  state_t           state_n;
  logic             accept;
  logic             done;
  logic             expire;
  logic             rec_done;
  logic             res_hs;
  logic [CNT_W-1:0] cnt;
  logic             tc;
  logic [RC_W-1:0]  rcnt;

  fun_req_master_wait_timer #(
    .CNT_W           (CNT_W),
    .MAX_WAIT_CYCLES (MAX_WAIT_CYCLES)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (state == S_SETTLE),
    .en  ((state == S_WAIT) && bus.fun_busy),
    .cnt (cnt),
    .tc  (tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    accept   = 1'b0;
    done     = 1'b0;
    expire   = 1'b0;
    rec_done = 1'b0;
    res_hs   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          accept  = 1'b1;
          state_n = S_START;
        end
      end
      S_START:  state_n = S_SETTLE;
      S_SETTLE: state_n = S_WAIT;
      S_WAIT: begin
        if (!bus.fun_busy) begin
          done    = 1'b1;
          state_n = S_RESP;
        end else if (tc) begin
          expire  = 1'b1;
          state_n = S_RECOVER;
        end
      end
      S_RECOVER: begin
        if (rcnt == RC_W'(RST_CYCLES - 1)) begin
          rec_done = 1'b1;
          state_n  = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.res_ready) begin
          res_hs  = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.req_ready   <= 1'b0;
      bus.fun_a       <= '0;
      bus.fun_b       <= '0;
      bus.fun_start   <= 1'b0;
      bus.fun_rst     <= 1'b1;
      bus.res_valid   <= 1'b0;
      bus.res_data    <= '0;
      bus.res_cycles  <= '0;
      bus.res_timeout <= 1'b0;
      rcnt            <= '0;
    end else begin
      bus.fun_start <= accept;
      if (accept) begin
        bus.req_ready <= 1'b0;
        bus.fun_a     <= bus.req_a;
        bus.fun_b     <= bus.req_b;
      end else if (state == S_IDLE || res_hs) begin
        bus.req_ready <= 1'b1;
      end
      if (done) begin
        bus.res_data    <= bus.fun_result;
        bus.res_cycles  <= cnt;
        bus.res_timeout <= 1'b0;
      end
      // Timeout: report zero data and hold fun in reset to flush it
      if (expire) begin
        bus.res_data    <= '0;
        bus.res_cycles  <= cnt;
        bus.res_timeout <= 1'b1;
        bus.fun_rst     <= 1'b1;
        rcnt            <= '0;
      end else if (rec_done || state == S_IDLE) begin
        bus.fun_rst <= 1'b0;
      end else if (state == S_RECOVER) begin
        rcnt <= rcnt + RC_W'(1);
      end
      if (done || rec_done) begin
        bus.res_valid <= 1'b1;
      end else if (res_hs) begin
        bus.res_valid <= 1'b0;
      end
    end
  end

endmodule
